// File: rtl/seg7_pkg.sv
// Shared types, constants and the BCD-to-segment decode for the seven-segment scan driver.
// Cathode patterns are active-low, bit 0 = segment a through bit 6 = segment g.
package seg7_pkg;

   typedef logic [6:0] seg7_t;

   typedef enum logic {
      GAP   = 1'b0,
      DIGIT = 1'b1
   } scan_state_t;

   localparam seg7_t SEG_BLANK = 7'h7F;
   localparam seg7_t SEG_DASH  = 7'b0111111;

   // Codes above 9 are not valid BCD, so they show a dash instead of garbage.
   function automatic seg7_t bcd_to_seg7(input logic [3:0] i_bcd);
      seg7_t r;
      case (i_bcd)
         4'd0:    r = 7'b1000000;
         4'd1:    r = 7'b1111001;
         4'd2:    r = 7'b0100100;
         4'd3:    r = 7'b0110000;
         4'd4:    r = 7'b0011001;
         4'd5:    r = 7'b0010010;
         4'd6:    r = 7'b0000010;
         4'd7:    r = 7'b1111000;
         4'd8:    r = 7'b0000000;
         4'd9:    r = 7'b0010000;
         default: r = SEG_DASH;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bcd_seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment cathode pattern.
module bcd_seg7_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] i_bcd,
   output seg7_t      o_seg
);

   assign o_seg = bcd_to_seg7(i_bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver with an all-off gap between digit slots and a per-frame digit snapshot.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3 and 2.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int         CLK_HZ  = 100000000,
   parameter int         SLOT_HZ = 4000,
   parameter int         GAP_CYC = 200,
   parameter logic [3:0] DP_MASK = 4'b0010
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  d0,
   input  logic [3:0]  d1,
   input  logic [3:0]  d2,
   input  logic [3:0]  d3,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_done,
   output scan_state_t o_dbg_state
);

   localparam int DIV = CLK_HZ / SLOT_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CW-1:0] DIG_END   = CW'(DIV - GAP_CYC - 1);
   localparam logic [CW-1:0] GAP_START = CW'(DIV - GAP_CYC);
   localparam logic [CW-1:0] SLOT_END  = CW'(DIV - 1);

   scan_state_t      r_state;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_idx;
   logic [3:0][3:0]  r_snap;
   logic [3:0]       r_an;
   seg7_t            r_seg;
   logic             r_dp;
   logic             r_frame_done;

   scan_state_t      w_state_nx;
   logic [CW-1:0]    w_cnt_eff;
   logic [CW-1:0]    w_cnt_nx;
   logic [1:0]       w_idx_nx;
   logic             w_frame_end;
   logic             w_blank;
   seg7_t            w_seg_dec;

   // Reset parks the FSM in GAP with the counter at 0; that count stands for the
   // first gap clock, so the post-reset gap is exactly GAP_CYC clocks long.
   always_comb begin
      w_cnt_eff   = r_cnt;
      if (r_state == GAP && r_cnt < GAP_START)
         w_cnt_eff = GAP_START;
      w_state_nx  = r_state;
      w_cnt_nx    = w_cnt_eff + 1'b1;
      w_idx_nx    = r_idx;
      w_frame_end = 1'b0;
      case (r_state)
         DIGIT: begin
            if (r_cnt == DIG_END)
               w_state_nx = GAP;
         end
         GAP: begin
            if (w_cnt_eff == SLOT_END) begin
               w_state_nx  = DIGIT;
               w_cnt_nx    = '0;
               w_idx_nx    = r_idx + 2'd1;
               w_frame_end = (r_idx == 2'd3);
            end
         end
         default: w_state_nx = GAP;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= GAP;
         r_cnt        <= '0;
         r_idx        <= 2'd3;
         r_snap       <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_cnt        <= w_cnt_nx;
         r_idx        <= w_idx_nx;
         r_frame_done <= w_frame_end;
         if (w_frame_end)
            r_snap <= {d3, d2, d1, d0};
      end
   end

   bcd_seg7_decoder u_dec (
      .i_bcd (r_snap[r_idx]),
      .o_seg (w_seg_dec)
   );

   always_comb begin
      w_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (r_idx == 2'd3)
         w_blank = (r_snap[3] == 4'd0);
      else if (r_idx == 2'd2)
         w_blank = (r_snap[3] == 4'd0) && (r_snap[2] == 4'd0);
`endif
   end

   // Display outputs trail the state register by one clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_an  <= 4'hF;
         r_seg <= SEG_BLANK;
         r_dp  <= 1'b1;
      end else if (r_state == DIGIT) begin
         r_an  <= ~(4'b0001 << r_idx);
         r_seg <= w_blank ? SEG_BLANK : w_seg_dec;
         r_dp  <= ~DP_MASK[r_idx];
      end else begin
         r_an  <= 4'hF;
         r_seg <= SEG_BLANK;
         r_dp  <= 1'b1;
      end
   end

   assign an          = r_an;
   assign seg         = r_seg;
   assign dp          = r_dp;
   assign frame_done  = r_frame_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=10, GAP_CYC=2 (40-clock frames).
module tb_seg7_scan_driver;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] SD   = 7'b0111111;
  localparam logic [6:0] SB   = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0, d3 = 4'd0;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;
  logic frame_done;
  seg7_pkg::scan_state_t dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic e_dp, e_fd;
  logic [6:0] exp_seg [4];

  seg7_scan_driver #(
    .CLK_HZ(100), .SLOT_HZ(10), .GAP_CYC(2), .DP_MASK(4'b0010)
  ) dut (
    .clock(clock), .reset(reset),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done),
    .o_dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_expected(input bit lit, input int s, input int c);
    e_an = 4'hF;
    e_seg = SB;
    e_dp = 1'b1;
    if (lit) begin
      e_an[s] = 1'b0;
      e_seg = exp_seg[s];
      e_dp = (s == 1) ? 1'b0 : 1'b1;
    end
    e_fd = (s == 3 && c == 9);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({an, seg, dp, frame_done} !== {4'hF, SB, 1'b1, 1'b0})
      $display("FAIL reset_outputs: an=%b seg=%b dp=%b fd=%b, expected 1111/1111111/1/0", an, seg, dp, frame_done);
    else n_pass++;
    n_checks++;
    if (dbg_state !== seg7_pkg::GAP)
      $display("FAIL reset_state: state=%0d expected GAP", dbg_state);
    else n_pass++;
  endtask

  // Releases reset and checks the whole first frame (snapshot of zeros).
  task automatic test_first_frame();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({an, frame_done} !== {4'hF, 1'b0})
      $display("FAIL first_e1: an=%b fd=%b expected 1111/0", an, frame_done);
    else n_pass++;
    tick();
    n_checks++;
    if ({an, frame_done, dbg_state} !== {4'hF, 1'b1, seg7_pkg::DIGIT})
      $display("FAIL first_e2: an=%b fd=%b state=%0d expected 1111/1/DIGIT", an, frame_done, dbg_state);
    else n_pass++;
    exp_seg[0] = S0; exp_seg[1] = S0;
    exp_seg[2] = LZB ? SB : S0; exp_seg[3] = LZB ? SB : S0;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 10; c++) begin
        tick();
        set_expected(c < 8, s, c);
        n_checks++;
        if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd})
          $display("FAIL first_frame s%0d c%0d: an=%b seg=%b dp=%b fd=%b expected %b/%b/%b/%b",
                   s, c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
        else n_pass++;
      end
  endtask

  // New inputs applied at the frame start must not show until the next frame.
  task automatic test_snapshot_hold();
    d3 = 4'd5; d2 = 4'd9; d1 = 4'd4; d0 = 4'd7;
    exp_seg[0] = S0; exp_seg[1] = S0;
    exp_seg[2] = LZB ? SB : S0; exp_seg[3] = LZB ? SB : S0;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 10; c++) begin
        tick();
        set_expected(c < 8, s, c);
        n_checks++;
        if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd})
          $display("FAIL snapshot_hold s%0d c%0d: an=%b seg=%b dp=%b fd=%b expected %b/%b/%b/%b",
                   s, c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
        else n_pass++;
      end
  endtask

  task automatic test_held_digits();
    exp_seg[0] = S7; exp_seg[1] = S4; exp_seg[2] = S9; exp_seg[3] = S5;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 10; c++) begin
        tick();
        if (s == 2 && c == 0) d0 = 4'd3;
        set_expected(c < 8, s, c);
        n_checks++;
        if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd})
          $display("FAIL held_digits s%0d c%0d: an=%b seg=%b dp=%b fd=%b expected %b/%b/%b/%b",
                   s, c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
        else n_pass++;
      end
  endtask

  task automatic test_midframe_change();
    exp_seg[0] = S3; exp_seg[1] = S4; exp_seg[2] = S9; exp_seg[3] = S5;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 10; c++) begin
        tick();
        if (s == 0 && c == 0) d1 = 4'hC;
        set_expected(c < 8, s, c);
        n_checks++;
        if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd})
          $display("FAIL midframe_change s%0d c%0d: an=%b seg=%b dp=%b fd=%b expected %b/%b/%b/%b",
                   s, c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
        else n_pass++;
      end
  endtask

  task automatic test_dash();
    exp_seg[0] = S3; exp_seg[1] = SD; exp_seg[2] = S9; exp_seg[3] = S5;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 10; c++) begin
        tick();
        set_expected(c < 8, s, c);
        n_checks++;
        if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd})
          $display("FAIL dash s%0d c%0d: an=%b seg=%b dp=%b fd=%b expected %b/%b/%b/%b",
                   s, c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
        else n_pass++;
      end
  endtask

  task automatic test_reset_mid_digit();
    repeat (4) tick();
    n_checks++;
    if ({an, seg} !== {4'b1110, S3})
      $display("FAIL mid_digit_pre: an=%b seg=%b expected 1110/%b", an, seg, S3);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({an, seg, dp, frame_done} !== {4'hF, SB, 1'b1, 1'b0})
      $display("FAIL async_reset: an=%b seg=%b dp=%b fd=%b expected 1111/1111111/1/0", an, seg, dp, frame_done);
    else n_pass++;
    d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
    repeat (2) tick();
    n_checks++;
    if ({an, dbg_state} !== {4'hF, seg7_pkg::GAP})
      $display("FAIL reset_hold: an=%b state=%0d expected 1111/GAP", an, dbg_state);
    else n_pass++;
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_leading_zero_blank();
    logic [6:0] tbl [3][4];
    tbl[0] = '{S0, S0, SB, SB};
    tbl[1] = '{S5, S0, SB, SB};
    tbl[2] = '{S0, S0, S1, SB};
    for (int f = 0; f < 3; f++) begin
      if (f == 0) begin d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd5; end
      if (f == 1) begin d3 = 4'd0; d2 = 4'd1; d1 = 4'd0; d0 = 4'd0; end
      for (int i = 0; i < 4; i++) exp_seg[i] = tbl[f][i];
      for (int s = 0; s < 4; s++)
        for (int c = 0; c < 10; c++) begin
          tick();
          set_expected(c < 8, s, c);
          n_checks++;
          if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd})
            $display("FAIL lz_blank f%0d s%0d c%0d: an=%b seg=%b dp=%b fd=%b expected %b/%b/%b/%b",
                     f, s, c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
          else n_pass++;
        end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_snapshot_hold();
    test_held_digits();
    test_midframe_change();
    test_dash();
    test_reset_mid_digit();
    test_first_frame();
`ifdef LEADING_ZERO_BLANK_EN
    test_leading_zero_blank();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
